// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the core's single data-memory port with one external requester.
//
// The core owns the port by default. A pending external request is granted when the core
// is idle, or after it has lost MAX_WAIT contested cycles. A granted access holds the port
// for one cycle (EXT_ACCESS), and the core sees cpu_stall during that cycle if it was
// accessing memory. An ext_ack pulse follows in the next cycle (EXT_ACK).
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cpu_daddr/dread/dwrite/   core data-port request
//   cpu_dwdata
//   cpu_ddata, cpu_stall      read data to the core, core-not-serviced flag
//   ext_req/we/addr/wdata     external request, level, held until ext_ack
//   ext_ack, ext_rdata        one-cycle completion pulse, registered read data
//   mem_addr/read/write/      data memory port; mem_rdata is a combinational read
//   wdata, mem_rdata
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_daddr,
  input  logic        cpu_dread,
  input  logic        cpu_dwrite,
  input  logic [15:0] cpu_dwdata,
  output logic [15:0] cpu_ddata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [15:0] ext_addr,
  input  logic [15:0] ext_wdata,
  output logic        ext_ack,
  output logic [15:0] ext_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    StCpuOwn,
    StExtAccess,
    StExtAck
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [15:0] ext_wdata_q, ext_wdata_d;
  logic        ext_we_q, ext_we_d;
  logic [15:0] ext_rdata_q, ext_rdata_d;

  logic cpu_req;
  assign cpu_req = cpu_dread | cpu_dwrite;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StCpuOwn;
      wait_cnt_q  <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    ext_rdata_d = ext_rdata_q;
    case (state_q)
      StCpuOwn: begin
        if (ext_req && (!cpu_req || wait_cnt_q == MaxWait)) begin
          // Grant edge: the access is frozen here, later ext_* changes are ignored.
          state_d     = StExtAccess;
          wait_cnt_d  = '0;
          ext_addr_d  = ext_addr;
          ext_wdata_d = ext_wdata;
          ext_we_d    = ext_we;
        end else if (ext_req) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          // A request dropped before its grant is cancelled.
          wait_cnt_d = '0;
        end
      end
      StExtAccess: begin
        state_d = StExtAck;
        if (!ext_we_q) begin
          ext_rdata_d = mem_rdata;
        end
      end
      StExtAck: begin
        state_d = StCpuOwn;
      end
      default: begin
        state_d = StCpuOwn;
      end
    endcase
  end

  // Outputs
  always_comb begin
    mem_addr  = cpu_daddr;
    mem_wdata = cpu_dwdata;
    mem_write = cpu_dwrite;
    mem_read  = cpu_dread & ~cpu_dwrite;  // read+write from the core counts as a write
    cpu_stall = 1'b0;
    if (state_q == StExtAccess) begin
      mem_addr  = ext_addr_q;
      mem_wdata = ext_wdata_q;
      mem_write = ext_we_q;
      mem_read  = ~ext_we_q;
      cpu_stall = cpu_req;
    end
    // Reset kills any in-flight memory access, including an external write.
    if (reset) begin
      mem_write = 1'b0;
      mem_read  = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  assign ext_ack   = (state_q == StExtAck);
  assign ext_rdata = ext_rdata_q;
  assign cpu_ddata = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-cycle LEGLite core's one data-memory port with an external requester (I/O loader / debug port). It sits between the core's `daddr`/`dread`/`dwrite`/`dwdata`/`ddata` pins and the data memory. The core owns the port by default. An external access takes the port for one cycle, with a bounded wait, and the core receives `cpu_stall` for that cycle so it can hold its PC.

## Interface
Parameters:
- MAX_WAIT, default 4: number of contested cycles the external requester can lose before it is forced through. Legal range 0–15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_daddr  in  16  core data address
- cpu_dread  in  1  core read enable
- cpu_dwrite  in  1  core write enable
- cpu_dwdata  in  16  core write data
- cpu_ddata  out  16  read data to core; equals mem_rdata
- cpu_stall  out  1  core access not serviced this cycle
- ext_req  in  1  external request, level; held until ext_ack
- ext_we  in  1  external access is a write (1) or a read (0)
- ext_addr  in  16  external address
- ext_wdata  in  16  external write data
- ext_ack  out  1  one-cycle completion pulse
- ext_rdata  out  16  registered external read data
- mem_addr  out  16  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_wdata  out  16  to data memory
- mem_rdata  in  16  data memory output; combinational read

## Operation
- `cpu_req` = `cpu_dread` | `cpu_dwrite`. If both are high, the access is treated as a write: `mem_write`=1 and `mem_read`=0.
- States: CPU_OWN (reset state), EXT_ACCESS, EXT_ACK.
- Registered state: `wait_cnt` (4 bits), and `ext_addr_q`, `ext_wdata_q`, `ext_we_q`, which are captured on the CPU_OWN→EXT_ACCESS edge.

CPU_OWN
- Memory pins are a combinational pass-through of the cpu_* signals. `cpu_stall`=0.
- If `ext_req`=1 and (`cpu_req`=0 or `wait_cnt`==MAX_WAIT): latch the ext_* inputs, clear `wait_cnt`, and go to EXT_ACCESS.
- Else if `ext_req`=1 and `cpu_req`=1: `wait_cnt`++.
- Else (`ext_req`=0): clear `wait_cnt`. Dropping the request before the grant cancels it.

EXT_ACCESS
- Memory is driven from the latched ext values: `mem_write`=`ext_we_q`, `mem_read`=!`ext_we_q`.
- `cpu_stall`=`cpu_req`.
- `ext_rdata` ← `mem_rdata` on a read. On a write, `ext_rdata` holds its previous value.
- Always go to EXT_ACK.

EXT_ACK
- `ext_ack`=1. Memory returns to CPU pass-through. `cpu_stall`=0.
- `ext_req` is ignored in this cycle. Always go to CPU_OWN.
- The external requester must deassert `ext_req` or present a new request. Back-to-back external accesses are therefore at least 3 cycles apart.

Outputs:
- `cpu_ddata` = `mem_rdata` in every state.

## Timing
- Uncontested external access: `ext_req` rises in cycle 0 → EXT_ACCESS in cycle 1 → `ext_ack`=1 and `ext_rdata` valid in cycle 2.
- Contested external access: the external requester waits MAX_WAIT cycles. With MAX_WAIT=4 and the core busy every cycle, grant is in cycle 5 and ack in cycle 6.
- MAX_WAIT=0: the external requester always wins on the first cycle of its request.
- Reset:
  - Registered values while reset is high and on the first cycle after: state=CPU_OWN, `ext_ack`=0, `ext_rdata`=0, `wait_cnt`=0, latches=0.
  - `mem_write` and `mem_read` are forced to 0 while reset is high. This aborts an in-flight EXT_ACCESS write.
  - `cpu_stall`=0 during reset.
- ext_* inputs are sampled only at the grant edge. Changes after that edge do not affect the access in flight.
- Core-side pass-through adds no latency. `cpu_stall` is combinational from state and the `cpu_*` enables.

## Test plan
- Idle core:
  - Stimulus: `ext_req`=1, `ext_we`=0, `ext_addr`=0x0010, memory[0x0010]=0xBEEF, core issues no request.
  - Required: grant in cycle 1, `ext_ack` in cycle 2, `ext_rdata`=0xBEEF, `cpu_stall` never asserted.
- Starvation bound:
  - Stimulus: core reads every cycle, `ext_req` held from cycle 0, MAX_WAIT=4.
  - Required: `cpu_stall`=1 only in cycle 5, `ext_ack` in cycle 6, `wait_cnt` back at 0.
- External write:
  - Stimulus: `ext_we`=1, `ext_addr`=0x0020, `ext_wdata`=0x1234. Change `ext_wdata` to 0xFFFF one cycle after the grant.
  - Required: memory[0x0020]=0x1234, and a core read of 0x0020 afterwards returns 0x1234.
- Cancel:
  - Stimulus: core busy, `ext_req` held for 2 cycles then dropped.
  - Required: no EXT_ACCESS, no `ext_ack`, `wait_cnt`=0, `cpu_stall` never asserted.
- Reset mid-access:
  - Stimulus: reset asserted during an EXT_ACCESS write to 0x0030, which holds 0x0000 beforehand.
  - Required: `mem_write`=0 in that cycle, memory[0x0030] still 0x0000, next state CPU_OWN, `ext_ack` never asserted.
- Core write plus read:
  - Stimulus: `cpu_dwrite`=`cpu_dread`=1 at 0x0040 with data 0x00AA.
  - Required: `mem_write`=1, `mem_read`=0, memory[0x0040]=0x00AA.
